// File: rtl/lsu_pkg.sv
// Shared encodings for the DFF RAM load/store controller.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam int unsigned RAM_BYTES      = 4 << ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/data, load extract + extension, alignment check.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdo,
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr_lo,
  output logic [3:0]  we,
  output logic [31:0] di,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdo[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdo[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    we    = 4'b0000;
    di    = wdata;
    rdata = 32'h0;
    case (size)
      SZ_BYTE: begin
        we    = 4'b0001 << addr_lo;
        di    = {4{wdata[7:0]}};
        rdata = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        we    = addr_lo[1] ? 4'b1100 : 4'b0011;
        di    = {2{wdata[15:0]}};
        rdata = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        we    = 4'b1111;
        rdata = rdo;
      end
      default: ;
    endcase
  end

  assign misaligned = ((chk_size == SZ_HALF) && chk_addr_lo[0]) ||
                      ((chk_size == SZ_WORD) && (chk_addr_lo != 2'b00));

endmodule

// File: rtl/dffram_lsu_ctrl.sv
// Single-outstanding load/store controller in front of a byte-writable DFF RAM.
module dffram_lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_EN,
  output logic [3:0]            ram_WE,
  output logic [ADDR_WIDTH-1:0] ram_A,
  output logic [DATA_WIDTH-1:0] ram_Di,
  input  logic [DATA_WIDTH-1:0] ram_Do
);

  localparam logic [32:0] RANGE_LIMIT = 33'd4 << ADDR_WIDTH;

  lsu_state_t            state_reg;
  logic                  we_reg;
  logic [1:0]            size_reg;
  logic                  unsigned_reg;
  logic [ADDR_WIDTH+1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_err_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;

  logic [3:0]            lane_we;
  logic [DATA_WIDTH-1:0] lane_di;
  logic [DATA_WIDTH-1:0] lane_rdata;
  logic                  misaligned;
  logic                  req_err;

  lsu_lane_align u_align (
    .size        (size_reg),
    .addr_lo     (addr_reg[1:0]),
    .is_unsigned (unsigned_reg),
    .wdata       (wdata_reg),
    .rdo         (ram_Do),
    .chk_size    (req_size),
    .chk_addr_lo (req_addr[1:0]),
    .we          (lane_we),
    .di          (lane_di),
    .rdata       (lane_rdata),
    .misaligned  (misaligned)
  );

  // Errors are decided on the incoming request so they never reach the RAM.
  assign req_err = (req_size == 2'b11) || misaligned || ({1'b0, req_addr} >= RANGE_LIMIT);

  assign req_ready = (state_reg == ST_IDLE) && !RST;
  assign ram_EN    = (state_reg == ST_ACCESS) && !RST;
  assign ram_WE    = (ram_EN && we_reg) ? lane_we : 4'b0000;
  assign ram_A     = addr_reg[ADDR_WIDTH+1:2];
  assign ram_Di    = lane_di;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg       <= req_we;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            addr_reg     <= req_addr[ADDR_WIDTH+1:0];
            wdata_reg    <= req_wdata;
            if (req_err) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              state_reg     <= ST_RESP;
            end else begin
              state_reg <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: state_reg <= ST_CAPTURE;
        ST_CAPTURE: begin
          // ram_Do now carries the word read during ACCESS.
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= we_reg ? '0 : lane_rdata;
          state_reg     <= ST_RESP;
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_lsu_ctrl.sv
// Directed bench for dffram_lsu_ctrl with a behavioural 2048x32 byte-writable RAM.
module tb_dffram_lsu_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_EN;
  logic [3:0]  ram_WE;
  logic [10:0] ram_A;
  logic [31:0] ram_Di;
  logic [31:0] ram_Do;

  int vectors = 0;
  int miscompares = 0;
  int stray_we = 0;

  logic [31:0] mem [0:2047];

  always #5 CLK = ~CLK;

  dffram_lsu_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di),
    .ram_Do(ram_Do)
  );

  // Registered-read RAM: Do returns the pre-write word of the addressed location.
  always @(posedge CLK) begin
    if (ram_EN) begin
      ram_Do <= mem[ram_A];
      for (int i = 0; i < 4; i++)
        if (ram_WE[i]) mem[ram_A][8*i +: 8] <= ram_Di[8*i +: 8];
    end
  end

  always @(negedge CLK)
    if (!ram_EN && ram_WE !== 4'b0000) stray_we++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string name, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                      input logic [3:0] exp_we, input logic [31:0] exp_di);
    int lat;
    int en_cnt;
    logic [3:0]  we_seen;
    logic [10:0] a_seen;
    logic [31:0] di_seen;
    lat = 0; en_cnt = 0; we_seen = 4'h0; a_seen = '0; di_seen = '0;
    @(negedge CLK);
    check({name, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_size = 2'b11;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge CLK);
      if (ram_EN) begin
        en_cnt++; we_seen = ram_WE; a_seen = ram_A; di_seen = ram_Di;
      end
      if (rsp_valid) lat = c;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({name, " rdata"}, rsp_rdata, exp_rdata);
    check({name, " en_cycles"}, en_cnt, exp_err ? 0 : 1);
    if (!exp_err) begin
      check({name, " WE"}, {28'b0, we_seen}, {28'b0, exp_we});
      check({name, " A"}, {21'b0, a_seen}, {21'b0, addr[12:2]});
      if (we) check({name, " Di"}, di_seen, exp_di);
    end
    @(negedge CLK);
    check({name, " pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({name, " hold"}, rsp_rdata, exp_rdata);
    $display("%-10s we=%0b size=%0d uns=%0b addr=%h -> lat=%0d err=%0b rdata=%h WE=%b",
             name, we, size, uns, addr, lat, rsp_err, rsp_rdata, we_seen);
  endtask

  initial begin
    int quiet;
    repeat (3) @(negedge CLK);
    check("rst ready", {31'b0, req_ready}, 32'd0);
    check("rst valid", {31'b0, rsp_valid}, 32'd0);
    check("rst err", {31'b0, rsp_err}, 32'd0);
    check("rst rdata", rsp_rdata, 32'd0);
    check("rst en", {31'b0, ram_EN}, 32'd0);
    RST = 1'b0;

    //    name        we    size   uns  addr          wdata         lat err rdata          WE       Di
    xact("sw10",     1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 3, 0, 32'h0,         4'b1111, 32'hDEADBEEF);
    xact("lw10",     1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        3, 0, 32'hDEADBEEF,  4'b0000, 32'h0);
    xact("sb13",     1'b1, 2'b00, 1'b0, 32'h13,       32'hABCDEF80, 3, 0, 32'h0,         4'b1000, 32'h80808080);
    xact("lb13",     1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        3, 0, 32'hFFFFFF80,  4'b0000, 32'h0);
    xact("lbu13",    1'b0, 2'b00, 1'b1, 32'h13,       32'h0,        3, 0, 32'h00000080,  4'b0000, 32'h0);
    xact("lbu10",    1'b0, 2'b00, 1'b1, 32'h10,       32'h0,        3, 0, 32'h000000EF,  4'b0000, 32'h0);
    xact("lh12",     1'b0, 2'b01, 1'b0, 32'h12,       32'h0,        3, 0, 32'hFFFF80AD,  4'b0000, 32'h0);
    xact("lw10b",    1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        3, 0, 32'h80ADBEEF,  4'b0000, 32'h0);
    xact("sh22",     1'b1, 2'b01, 1'b0, 32'h22,       32'h12348001, 3, 0, 32'h0,         4'b1100, 32'h80018001);
    xact("lh22",     1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        3, 0, 32'hFFFF8001,  4'b0000, 32'h0);
    xact("lhu22",    1'b0, 2'b01, 1'b1, 32'h22,       32'h0,        3, 0, 32'h00008001,  4'b0000, 32'h0);
    xact("sh20",     1'b1, 2'b01, 1'b0, 32'h20,       32'h00007FFF, 3, 0, 32'h0,         4'b0011, 32'h7FFF7FFF);
    xact("lh20",     1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        3, 0, 32'h00007FFF,  4'b0000, 32'h0);
    xact("lw20",     1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        3, 0, 32'h80017FFF,  4'b0000, 32'h0);
    xact("lw6_err",  1'b0, 2'b10, 1'b0, 32'h6,        32'h0,        1, 1, 32'h0,         4'b0000, 32'h0);
    xact("sh1_err",  1'b1, 2'b01, 1'b0, 32'h1,        32'h1234,     1, 1, 32'h0,         4'b0000, 32'h0);
    xact("lw2000",   1'b0, 2'b10, 1'b0, 32'h2000,     32'h0,        1, 1, 32'h0,         4'b0000, 32'h0);
    xact("sz11_err", 1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        1, 1, 32'h0,         4'b0000, 32'h0);
    xact("sbhi_err", 1'b1, 2'b00, 1'b0, 32'h8000_0004,32'hFF,       1, 1, 32'h0,         4'b0000, 32'h0);
    xact("sw1ffc",   1'b1, 2'b10, 1'b0, 32'h1FFC,     32'hA55A3CC3, 3, 0, 32'h0,         4'b1111, 32'hA55A3CC3);
    xact("lw1ffc",   1'b0, 2'b10, 1'b0, 32'h1FFC,     32'h0,        3, 0, 32'hA55A3CC3,  4'b0000, 32'h0);
    xact("sw0",      1'b1, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 3, 0, 32'h0,         4'b1111, 32'hCAFEF00D);
    xact("lw0",      1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        3, 0, 32'hCAFEF00D,  4'b0000, 32'h0);

    // Reset lands while the store is in ACCESS: the write must be suppressed.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h12345678;
    @(posedge CLK);
    #1 req_valid = 1'b0; RST = 1'b1;
    @(negedge CLK);
    check("rstacc en", {31'b0, ram_EN}, 32'd0);
    check("rstacc we", {28'b0, ram_WE}, 32'd0);
    check("rstacc ready", {31'b0, req_ready}, 32'd0);
    @(negedge CLK);
    check("rstacc valid", {31'b0, rsp_valid}, 32'd0);
    check("rstacc rdata", rsp_rdata, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(negedge CLK);
      if (rsp_valid || ram_EN) quiet++;
    end
    check("rstacc no_rsp", quiet, 0);
    $display("rst_access sw addr=00000000 wdata=12345678 dropped, activity=%0d", quiet);
    xact("lw0_after", 1'b0, 2'b10, 1'b0, 32'h0,      32'h0,        3, 0, 32'hCAFEF00D,  4'b0000, 32'h0);

    check("stray WE", stray_we, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
